// File: rtl/sort6_stream_pkg.sv
// Shared constants and state encoding for the six-entry streaming sorter.
package sort6_stream_pkg;

    localparam int DATA_W = 11;
    localparam int N      = 6;
    localparam int IDX_W  = 3;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sort6_stream_cmp_idx.sv
// Two-input minimum on (valid, value, idx) triples; lower index wins ties,
// an invalid operand always loses.
module cmp_idx
    import sort6_stream_pkg::*;
(
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic [IDX_W-1:0]  b_idx,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic [IDX_W-1:0]  y_idx
);

    logic pick_a;

    always_comb begin
        pick_a = a_valid && (!b_valid || (a_data < b_data) ||
                             ((a_data == b_data) && (a_idx < b_idx)));
        y_valid = a_valid || b_valid;
        y_data  = pick_a ? a_data : b_data;
        y_idx   = pick_a ? a_idx  : b_idx;
    end

endmodule

// File: rtl/sort6_stream.sv
// Captures six values per frame, then streams them out smallest-first with
// their arrival slot, using a 3-level cmp_idx tree over the live entries.
module sort6_stream
    import sort6_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  load_cnt_reg, load_cnt_next;
    logic [IDX_W-1:0]  emit_cnt_reg, emit_cnt_next;
    logic [DATA_W-1:0] slot_reg  [N];
    logic [DATA_W-1:0] slot_next [N];
    logic [N-1:0]      mask_reg, mask_next;

    logic              l1_valid [3];
    logic [DATA_W-1:0] l1_data  [3];
    logic [IDX_W-1:0]  l1_idx   [3];
    logic              l2_valid;
    logic [DATA_W-1:0] l2_data;
    logic [IDX_W-1:0]  l2_idx;
    logic              min_valid;
    logic [DATA_W-1:0] min_data;
    logic [IDX_W-1:0]  min_idx;

    logic in_accept, out_accept;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_l1
            localparam logic [IDX_W-1:0] A_IDX = IDX_W'(2 * gi);
            localparam logic [IDX_W-1:0] B_IDX = IDX_W'(2 * gi + 1);
            cmp_idx u_cmp (
                .a_valid (mask_reg[2*gi]),
                .a_data  (slot_reg[2*gi]),
                .a_idx   (A_IDX),
                .b_valid (mask_reg[2*gi+1]),
                .b_data  (slot_reg[2*gi+1]),
                .b_idx   (B_IDX),
                .y_valid (l1_valid[gi]),
                .y_data  (l1_data[gi]),
                .y_idx   (l1_idx[gi])
            );
        end
    endgenerate

    cmp_idx u_l2 (
        .a_valid (l1_valid[0]),
        .a_data  (l1_data[0]),
        .a_idx   (l1_idx[0]),
        .b_valid (l1_valid[1]),
        .b_data  (l1_data[1]),
        .b_idx   (l1_idx[1]),
        .y_valid (l2_valid),
        .y_data  (l2_data),
        .y_idx   (l2_idx)
    );

    cmp_idx u_l3 (
        .a_valid (l2_valid),
        .a_data  (l2_data),
        .a_idx   (l2_idx),
        .b_valid (l1_valid[2]),
        .b_data  (l1_data[2]),
        .b_idx   (l1_idx[2]),
        .y_valid (min_valid),
        .y_data  (min_data),
        .y_idx   (min_idx)
    );

    // Outputs are forced to zero outside EMIT so LOAD never exposes partial data.
    always_comb begin
        in_ready  = (state_reg == LOAD);
        out_valid = (state_reg == EMIT) && min_valid;
        out_data  = out_valid ? min_data : '0;
        out_idx   = out_valid ? min_idx  : '0;
        out_last  = out_valid && (emit_cnt_reg == IDX_W'(N - 1));
        busy      = !((state_reg == LOAD) && (load_cnt_reg == '0));
        in_accept  = in_valid && in_ready;
        out_accept = out_valid && out_ready;
    end

    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        emit_cnt_next = emit_cnt_reg;
        slot_next     = slot_reg;
        mask_next     = mask_reg;
        case (state_reg)
            LOAD: begin
                if (in_accept) begin
                    slot_next[load_cnt_reg] = in_data;
                    mask_next[load_cnt_reg] = 1'b1;
                    if (load_cnt_reg == IDX_W'(N - 1)) begin
                        load_cnt_next = '0;
                        state_next    = EMIT;
                    end else begin
                        load_cnt_next = load_cnt_reg + IDX_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_accept) begin
                    mask_next[min_idx] = 1'b0;
                    if (emit_cnt_reg == IDX_W'(N - 1)) begin
                        emit_cnt_next = '0;
                        mask_next     = '0;
                        state_next    = LOAD;
                    end else begin
                        emit_cnt_next = emit_cnt_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOAD;
            load_cnt_reg <= '0;
            emit_cnt_reg <= '0;
            mask_reg     <= '0;
            for (int i = 0; i < N; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
            emit_cnt_reg <= emit_cnt_next;
            mask_reg     <= mask_next;
            slot_reg     <= slot_next;
        end
    end

endmodule

// File: tb/tb_sort6_stream.sv
// Self-checking bench for sort6_stream: directed frames plus random frames
// compared against a stable-selection reference of each captured frame.
module tb_sort6_stream;

    typedef logic [10:0] frame_t [6];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sort6_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected emission order: repeatedly take the smallest unused value,
    // earliest arrival first on equal values.
    function automatic void ref_order(input frame_t v, output int ord [6]);
        bit used [6];
        for (int j = 0; j < 6; j++) used[j] = 0;
        for (int k = 0; k < 6; k++) begin
            int best = -1;
            for (int j = 0; j < 6; j++)
                if (!used[j] && (best < 0 || v[j] < v[best])) best = j;
            used[best] = 1;
            ord[k] = best;
        end
    endfunction

    // Drives values start..5; with gaps, in_valid alternates 1,0,1,0...
    task automatic load_frame(input frame_t v, input bit gaps, input int start);
        int i = start;
        int cyc = 0;
        bit tog = 1'b1;
        while (i < 6) begin
            @(negedge clk);
            chk("load_in_ready", int'(in_ready), 1);
            chk("load_busy", int'(busy), (i > 0) ? 1 : 0);
            in_valid = gaps ? tog : 1'b1;
            tog = ~tog;
            in_data = v[i];
            if (in_valid) i++;
            cyc++;
            if (cyc > 40) begin
                chk("load_timeout", cyc, 0);
                break;
            end
        end
    endtask

    // Collects n_out outputs; stall holds out_ready low for that many cycles
    // at the first output; rnd_ready randomises out_ready per cycle.
    task automatic emit_frame(input frame_t v, input int stall, input bit rnd_ready,
                              input bit hold_iv, input int n_out);
        int ord [6];
        int k = 0;
        int cyc = 0;
        int st = stall;
        ref_order(v, ord);
        while (k < n_out) begin
            @(negedge clk);
            in_valid = hold_iv;
            in_data  = '0;
            chk("emit_out_valid", int'(out_valid), 1);
            chk("emit_in_ready", int'(in_ready), 0);
            chk("emit_data", int'(out_data), int'(v[ord[k]]));
            chk("emit_idx", int'(out_idx), ord[k]);
            chk("emit_last", int'(out_last), (k == 5) ? 1 : 0);
            if (st > 0) begin
                out_ready = 1'b0;
                st--;
            end else if (rnd_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (out_ready) begin
                $display("out k=%0d data=%0d idx=%0d last=%0d", k, out_data, out_idx, out_last);
                k++;
            end
            cyc++;
            if (cyc > 60) begin
                chk("emit_timeout", cyc, 0);
                break;
            end
        end
        if (n_out == 6) begin
            @(negedge clk);
            chk("post_in_ready", int'(in_ready), 1);
            chk("post_out_valid", int'(out_valid), 0);
            chk("post_busy", int'(busy), 0);
            chk("post_out_last", int'(out_last), 0);
            in_valid = hold_iv;
            in_data  = '0;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_idx"}, int'(out_idx), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        frame_t f;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Basic frame
        f = '{11'd5, 11'd3, 11'd9, 11'd1, 11'd7, 11'd2};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 0, 1'b0, 1'b0, 6);

        // Duplicates and max value
        f = '{11'd4, 11'd4, 11'd0, 11'd4, 11'd0, 11'd2047};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 0, 1'b0, 1'b0, 6);

        // Backpressure on the first output
        f = '{11'd5, 11'd3, 11'd9, 11'd1, 11'd7, 11'd2};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 3, 1'b0, 1'b0, 6);

        // Input gaps
        f = '{11'd10, 11'd20, 11'd30, 11'd40, 11'd50, 11'd60};
        load_frame(f, 1'b1, 0);
        emit_frame(f, 0, 1'b0, 1'b0, 6);

        // Reset mid-EMIT after two outputs
        f = '{11'd5, 11'd3, 11'd9, 11'd1, 11'd7, 11'd2};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 0, 1'b0, 1'b0, 2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        f = '{11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 0, 1'b0, 1'b0, 6);

        // in_valid held with data 0 during EMIT: captured only once back in LOAD
        f = '{11'd8, 11'd8, 11'd3, 11'd100, 11'd1, 11'd50};
        load_frame(f, 1'b0, 0);
        emit_frame(f, 0, 1'b0, 1'b1, 6);
        f = '{11'd0, 11'd7, 11'd7, 11'd2, 11'd9, 11'd1};
        load_frame(f, 1'b0, 1);
        emit_frame(f, 0, 1'b0, 1'b0, 6);

        // Random frames, random gaps and backpressure; small ranges force ties
        for (int n = 0; n < 25; n++) begin
            for (int j = 0; j < 6; j++)
                f[j] = (n % 2 == 0) ? 11'($urandom_range(0, 3)) : 11'($urandom_range(0, 2047));
            load_frame(f, 1'($urandom_range(0, 1)), 0);
            emit_frame(f, 0, 1'b1, 1'b0, 6);
        end

        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
